video_pattern_gen: RTL and testbench
====================================

Name: video_pattern_gen

Overview:
- Video stream source: generates raster timing (hsync, vsync, de) plus a selectable 24-bit test pattern.
- Drives the rgb/hsync/vsync/de input of the Sobel edge pipeline for bring-up and regression, in place of a camera or HDMI receiver.
- Frame start/stop is controlled by an enable handshake.
- Pattern changes take effect only on frame boundaries, so frames never tear.

Parameters:
H_ACTIVE, 1920, active pixels per line (must be <= 2100, the line-buffer limit)
H_FP, 88, horizontal front porch (pixels)
H_SYNC, 44, hsync pulse width (pixels)
H_BP, 148, horizontal back porch (pixels)
V_ACTIVE, 1080, active lines per frame
V_FP, 4, vertical front porch (lines)
V_SYNC, 5, vsync pulse width (lines)
V_BP, 36, vertical back porch (lines)
HSYNC_POL, 1, asserted level of hsync
VSYNC_POL, 1, asserted level of vsync

Ports:
clk  input  1  pixel clock, single clock domain
rst  input  1  synchronous, active-high reset
en  input  1  run request; level-sensitive
pattern_sel  input  2  0 colour bars, 1 gradient, 2 checkerboard, 3 grid
rgb_out  output  24  pixel; [7:0]=R, [15:8]=G, [23:16]=B
hsync  output  1  horizontal sync, polarity per HSYNC_POL
vsync  output  1  vertical sync, polarity per VSYNC_POL
de  output  1  data enable, high for active pixels
frame_start  output  1  one-cycle pulse coincident with output of pixel (0,0)

Behaviour:
- H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters.
- h_cnt runs 0..H_TOTAL-1 and wraps; v_cnt increments on h_cnt wrap and wraps at V_TOTAL-1. Both counters are 12 bits.
- Position map, per (h,v):
  - active when h<H_ACTIVE and v<V_ACTIVE;
  - hsync asserted when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, on every line including vertical blanking;
  - vsync asserted for whole lines with V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, so it changes only at h=0.
- All outputs are registered with 1-cycle latency: outputs at cycle t+1 describe the counter position at cycle t.
- FSM states:
  - IDLE: counters held at (0,0).
  - RUN: counting.
  - DRAIN: counting; en has dropped.
- FSM transitions:
  - IDLE -> RUN when en=1. The counter is at (0,0) on that cycle, so frame_start appears the next cycle.
  - RUN -> DRAIN when en=0.
  - DRAIN -> RUN when en=1; counting continues with no discontinuity.
  - DRAIN -> IDLE on the cycle the counter is at (H_TOTAL-1, V_TOTAL-1), so the current frame always completes.
  - RUN at the end of a frame wraps to (0,0) and pulses frame_start.
- Outputs while in IDLE: de=0, rgb_out=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, frame_start=0.
- Pattern latch: pattern_sel is sampled into a frame register when the counter is at (0,0) and state is IDLE->RUN or RUN. Mid-frame changes are ignored until the next frame.
- rgb_out = 0 whenever de=0.
- Pattern 0, colour bars:
  - BAR_W = H_ACTIVE/8, integer division at elaboration; the last bar absorbs the remainder.
  - Bar index comes from a bar counter and a pixel-in-bar counter (no runtime divide); both reset at h=0.
  - Order: white FFFFFF, yellow 00FFFF, cyan FFFF00, green 00FF00, magenta FF00FF, red 0000FF, blue FF0000, black 000000 (values given as {B,G,R}).
- Pattern 1, gradient: R=G=B=h[7:0].
- Pattern 2, checkerboard: white when h[4]^v[4], else black.
- Pattern 3, grid: white when h[3:0]==0 or v[3:0]==0, else black.
- Reset (any time, including mid-line):
  - takes effect on the next edge; state IDLE, counters (0,0);
  - outputs forced to the IDLE values above;
  - latched pattern reset to 0.
- Reset dominates en.

Test Plan:
- All tests use reduced parameters: H 16/2/3/3 (H_TOTAL=24), V 4/1/2/1 (V_TOTAL=8).
- Timing, en=1 held, pattern 2 -> de high 16 cycles per line for lines 0-3 only; hsync=1 at h=18..20 on all 8 lines; vsync=1 for 48 consecutive cycles (lines 5-6); frame_start every 192 cycles; first frame_start 2 cycles after the first edge with en=1.
- Colour bars, pattern 0 -> pixels 0,1=FFFFFF; 2,3=00FFFF; 4,5=FFFF00; ... 14,15=000000; rgb_out=0 at h=16..23.
- Pattern change: pattern_sel 0->3 during line 2 -> rest of the frame stays bars. Next frame is grid: line 0 all FFFFFF; line 1 pixel 0 FFFFFF, pixels 1..15 000000.
- en dropped at v=2 -> frame completes through (23,7), then IDLE outputs, no further frame_start. Separate run: en dropped, then re-asserted at v=5 -> next frame_start exactly 192 cycles after the previous one.
- rst pulsed at h=7, v=1 -> next cycle de=0, rgb_out=0, syncs deasserted. With en=1 after release, frame_start occurs 2 cycles later and (0,0) is restarted.
- HSYNC_POL=0, VSYNC_POL=0 -> hsync low at h=18..20, high otherwise and in reset; vsync low on lines 5-6 only.

Source files
------------

// File: rtl/video_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : video_pattern_gen
//  Description : Raster timing generator (hsync/vsync/de) with a selectable
//                24-bit test pattern, started and stopped by an enable level.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_pattern_gen #(
    parameter int H_ACTIVE  = 1920,
    parameter int H_FP      = 88,
    parameter int H_SYNC    = 44,
    parameter int H_BP      = 148,
    parameter int V_ACTIVE  = 1080,
    parameter int V_FP      = 4,
    parameter int V_SYNC    = 5,
    parameter int V_BP      = 36,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    output logic [23:0] rgb_out,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start
);

    localparam logic [11:0] c_h_active = 12'(H_ACTIVE);
    localparam logic [11:0] c_h_last   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] c_hs_start = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] c_hs_end   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] c_v_active = 12'(V_ACTIVE);
    localparam logic [11:0] c_v_last   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [11:0] c_vs_start = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] c_vs_end   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] c_bar_w    = 12'(H_ACTIVE / 8);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [11:0] r_h_cnt;
    logic [11:0] r_v_cnt;
    logic [2:0]  r_bar_idx;
    logic [11:0] r_bar_pix;
    logic [1:0]  r_pattern;
    logic [1:0]  w_pattern;
    logic        w_h_last;
    logic        w_frame_last;
    logic        w_origin;
    logic        w_latch;
    logic        w_running;
    logic        w_active;
    logic        w_hs_act;
    logic        w_vs_act;
    logic [23:0] w_pix;

    logic [23:0] r_rgb;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_de;
    logic        r_frame_start;

    assign w_h_last     = (r_h_cnt == c_h_last);
    assign w_frame_last = w_h_last && (r_v_cnt == c_v_last);
    assign w_origin     = (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
    assign w_running    = (r_state != c_st_idle);
    assign w_active     = (r_h_cnt < c_h_active) && (r_v_cnt < c_v_active);
    assign w_hs_act     = (r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end);
    assign w_vs_act     = (r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end);

    // The pixel at (0,0) must already use the newly sampled pattern.
    assign w_latch   = w_origin && ((r_state == c_st_run) || ((r_state == c_st_idle) && en));
    assign w_pattern = w_latch ? pattern_sel : r_pattern;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (en) w_state_nxt = c_st_run;
            c_st_run:   if (!en) w_state_nxt = c_st_drain;
            c_st_drain: begin
                if (en)                w_state_nxt = c_st_run;
                else if (w_frame_last) w_state_nxt = c_st_idle;
            end
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_h_cnt   <= 12'd0;
            r_v_cnt   <= 12'd0;
            r_bar_idx <= 3'd0;
            r_bar_pix <= 12'd0;
            r_pattern <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) r_pattern <= pattern_sel;
            if (!w_running) begin
                r_h_cnt   <= 12'd0;
                r_v_cnt   <= 12'd0;
                r_bar_idx <= 3'd0;
                r_bar_pix <= 12'd0;
            end else if (w_h_last) begin
                r_h_cnt   <= 12'd0;
                r_v_cnt   <= (r_v_cnt == c_v_last) ? 12'd0 : r_v_cnt + 12'd1;
                r_bar_idx <= 3'd0;
                r_bar_pix <= 12'd0;
            end else begin
                r_h_cnt <= r_h_cnt + 12'd1;
                // The last bar never advances, so it absorbs the remainder.
                if ((r_bar_pix == c_bar_w - 12'd1) && (r_bar_idx != 3'd7)) begin
                    r_bar_idx <= r_bar_idx + 3'd1;
                    r_bar_pix <= 12'd0;
                end else begin
                    r_bar_pix <= r_bar_pix + 12'd1;
                end
            end
        end
    end

    // Colours are {B,G,R}.
    always_comb begin
        w_pix = 24'h000000;
        case (w_pattern)
            2'd0: begin
                case (r_bar_idx)
                    3'd0:    w_pix = 24'hFFFFFF;
                    3'd1:    w_pix = 24'h00FFFF;
                    3'd2:    w_pix = 24'hFFFF00;
                    3'd3:    w_pix = 24'h00FF00;
                    3'd4:    w_pix = 24'hFF00FF;
                    3'd5:    w_pix = 24'h0000FF;
                    3'd6:    w_pix = 24'hFF0000;
                    default: w_pix = 24'h000000;
                endcase
            end
            2'd1:    w_pix = {r_h_cnt[7:0], r_h_cnt[7:0], r_h_cnt[7:0]};
            2'd2:    w_pix = {24{r_h_cnt[4] ^ r_v_cnt[4]}};
            default: w_pix = {24{(r_h_cnt[3:0] == 4'd0) || (r_v_cnt[3:0] == 4'd0)}};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !w_running) begin
            r_rgb         <= 24'h000000;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_de          <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_rgb         <= w_active ? w_pix : 24'h000000;
            r_hsync       <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
            r_vsync       <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
            r_de          <= w_active;
            r_frame_start <= w_origin;
        end
    end

    assign rgb_out     = r_rgb;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_video_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_pattern_gen
//  Description : Scoreboard bench for video_pattern_gen on a 24x8 raster,
//                with a second instance using active-low sync polarity.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_pattern_gen;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [23:0] rgb_out, rgb_out_n;
    logic        hsync, vsync, de, frame_start;
    logic        hsync_n, vsync_n, de_n, frame_start_n;

    always #5 clk = ~clk;

    video_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel),
        .rgb_out(rgb_out), .hsync(hsync), .vsync(vsync), .de(de),
        .frame_start(frame_start)
    );

    video_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut_n (
        .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel),
        .rgb_out(rgb_out_n), .hsync(hsync_n), .vsync(vsync_n), .de(de_n),
        .frame_start(frame_start_n)
    );

    // {rgb, hsync, vsync, de, frame_start, hsync_n, vsync_n}
    logic [29:0] sb_q[$];

    int n_assert = 0;
    int n_fail   = 0;
    int n_step   = 0;
    int m_state  = M_IDLE;
    int m_h      = 0;
    int m_v      = 0;
    logic [1:0] m_pat = 2'd0;
    int fs_total = 0;
    int fs_prev  = 0;
    bit fs_have_prev = 1'b0;
    int start_step = 0;
    bit start_pending = 1'b0;

    function automatic logic [23:0] exp_pix(input logic [1:0] pat, input int h, input int v);
        logic [23:0] bars [8];
        logic [11:0] hh;
        logic [11:0] vv;
        int idx;
        bars = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
                 24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000};
        hh = 12'(h);
        vv = 12'(v);
        idx = h / 2;
        if (idx > 7) idx = 7;
        case (pat)
            2'd0:    return bars[idx];
            2'd1:    return {hh[7:0], hh[7:0], hh[7:0]};
            2'd2:    return (hh[4] ^ vv[4]) ? 24'hFFFFFF : 24'h000000;
            default: return ((hh[3:0] == 4'd0) || (vv[3:0] == 4'd0)) ? 24'hFFFFFF : 24'h000000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [1:0] s);
        logic [29:0] ex;
        logic [23:0] rgb_e;
        logic hs_e, vs_e, de_e, fs_e;
        bit eof;
        bit idle_cycle;
        rst = r;
        en = e;
        pattern_sel = s;
        rgb_e = 24'h0; hs_e = 1'b0; vs_e = 1'b0; de_e = 1'b0; fs_e = 1'b0;
        idle_cycle = 1'b1;
        if (r) begin
            m_state = M_IDLE; m_h = 0; m_v = 0; m_pat = 2'd0;
        end else if (m_state == M_IDLE) begin
            if (e) begin
                m_state = M_RUN;
                start_step = n_step;
                start_pending = 1'b1;
            end
        end else begin
            idle_cycle = 1'b0;
            if (m_state == M_RUN && m_h == 0 && m_v == 0) m_pat = s;
            de_e  = (m_h < 16) && (m_v < 4);
            rgb_e = de_e ? exp_pix(m_pat, m_h, m_v) : 24'h0;
            hs_e  = (m_h >= 18) && (m_h <= 20);
            vs_e  = (m_v >= 5) && (m_v <= 6);
            fs_e  = (m_h == 0) && (m_v == 0);
            eof   = (m_h == 23) && (m_v == 7);
            if (m_h == 23) begin
                m_h = 0;
                m_v = (m_v == 7) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
            if (m_state == M_RUN) begin
                if (!e) m_state = M_DRAIN;
            end else begin
                if (e) m_state = M_RUN;
                else if (eof) m_state = M_IDLE;
            end
        end
        if (idle_cycle) fs_have_prev = 1'b0;
        ex = {rgb_e, hs_e, vs_e, de_e, fs_e, ~hs_e, ~vs_e};
        sb_q.push_back(ex);
        @(posedge clk);
        #1;
        n_step++;
        ex = sb_q.pop_front();
        n_assert++;
        assert ({rgb_out, hsync, vsync, de, frame_start, hsync_n, vsync_n} === ex) else begin
            n_fail++;
            $error("FAIL sb step%0d observed=%h expected=%h", n_step,
                   {rgb_out, hsync, vsync, de, frame_start, hsync_n, vsync_n}, ex);
        end
        if (frame_start === 1'b1) begin
            fs_total++;
            if (fs_have_prev) check("fs_period", 32'(n_step - fs_prev), 32'd192);
            if (start_pending) check("fs_latency", 32'(n_step - start_step), 32'd2);
            start_pending = 1'b0;
            fs_prev = n_step;
            fs_have_prev = 1'b1;
        end
    endtask

    task automatic run(input int n, input logic e, input logic [1:0] s);
        for (int i = 0; i < n; i++) step(1'b0, e, s);
    endtask

    task automatic run_until(input int h, input int v, input logic e, input logic [1:0] s);
        int guard;
        guard = 0;
        while (!(m_h == h && m_v == v) && guard < 400) begin
            step(1'b0, e, s);
            guard++;
        end
        check("run_until_bound", 32'(guard < 400), 32'd1);
    endtask

    int fs_before;

    initial begin
        // Reset and idle.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd2);
        check("rst_de", 32'(de), 32'd0);
        check("rst_hsync_n", 32'(hsync_n), 32'd1);
        run(2, 1'b0, 2'd2);

        // Timing with checkerboard, two full frames plus a little.
        run(2 * 192 + 10, 1'b1, 2'd2);

        // Colour bars frame, then switch to grid mid-frame.
        run_until(0, 0, 1'b1, 2'd0);
        run_until(5, 2, 1'b1, 2'd0);
        run_until(0, 0, 1'b1, 2'd3);
        run_until(20, 2, 1'b1, 2'd3);

        // Drop en at line 2: frame completes, then idle with no frame_start.
        fs_before = fs_total;
        run(250, 1'b0, 2'd3);
        check("drain_no_fs", 32'(fs_total), 32'(fs_before));
        check("drain_idle_vsync_n", 32'(vsync_n), 32'd1);

        // Restart, drop en, re-assert at line 5 before the frame ends.
        run(200, 1'b1, 2'd1);
        run_until(4, 1, 1'b1, 2'd1);
        run_until(0, 5, 1'b0, 2'd1);
        run(250, 1'b1, 2'd1);

        // Reset mid-line at (7,1), then restart.
        run_until(7, 1, 1'b1, 2'd0);
        step(1'b1, 1'b1, 2'd0);
        check("rst_mid_de", 32'(de), 32'd0);
        check("rst_mid_rgb", 32'(rgb_out), 32'd0);
        check("rst_mid_syncs", 32'({hsync, vsync, hsync_n, vsync_n}), 32'b0011);
        fs_before = fs_total;
        run(30, 1'b1, 2'd0);
        check("rst_restart_fs", 32'(fs_total - fs_before), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
